// File: rtl/adder_seq_n_pkg.sv
// rtl/adder_seq_n_pkg.sv - shared types and helpers for the multi-cycle adder
// Contents: FSM state encoding and the chunk-index width helper.
package adder_seq_n_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Width of the chunk index counter; never narrower than one bit so the
  // single-chunk configuration still has a legal vector.
  function automatic int idx_width(input int nsteps);
    return (nsteps > 1) ? $clog2(nsteps) : 1;
  endfunction

endpackage

// File: rtl/adder_seq_n_if.sv
// rtl/adder_seq_n_if.sv - request/result bundle for the multi-cycle adder
// master: drives start, x, y, carry_in, sub; observes busy, done, sum, carry_out, overflow.
// slave : the adder side of the same signals.
interface adder_seq_n_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             carry_in;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, x, y, carry_in, sub,
    input  busy, done, sum, carry_out, overflow
  );

  modport slave (
    input  start, x, y, carry_in, sub,
    output busy, done, sum, carry_out, overflow
  );
endinterface

// File: rtl/adder_seq_n_chunk.sv
// rtl/adder_seq_n_chunk.sv - CHUNK-bit ripple adder built from full_adder cells
// Ports: a, b (CHUNK bits), cin in; sum (CHUNK bits), carry_out, carry_msb out.
// carry_msb is the carry into the top bit, used by the parent for signed overflow.
module adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             carry_out,
  output logic             carry_msb
);
  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

  assign carry_out = c[CHUNK];
  assign carry_msb = c[CHUNK-1];
endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
// Ports: a, b, cin in; s (sum bit), cout (carry out) out.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/adder_seq_n.sv
// rtl/adder_seq_n.sv - multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock
// Ports: clk, rst_n (sync, active-low); bus (slave): start/x/y/carry_in/sub in,
//        busy/done/sum/carry_out/overflow out.
module adder_seq_n
  import adder_seq_n_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  adder_seq_n_if.slave bus
);
  localparam int NSTEPS = WIDTH / CHUNK;
  localparam int IDXW   = idx_width(NSTEPS);
  localparam logic [IDXW-1:0] K_LAST = IDXW'(NSTEPS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [IDXW-1:0]  k_q, k_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] a_sel, b_sel, ch_sum;
  logic             ch_cout, ch_cmsb;

  // One adder slice shared by every chunk; the index picks its operands.
  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a         (a_sel),
    .b         (b_sel),
    .cin       (c_q),
    .sum       (ch_sum),
    .carry_out (ch_cout),
    .carry_msb (ch_cmsb)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NSTEPS; i++) begin
      if (k_q == IDXW'(i)) begin
        a_sel = a_q[i*CHUNK +: CHUNK];
        b_sel = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    k_d     = k_q;
    w_d     = w_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.x;
          // Subtraction folds into addition of the complement; carry_in=1
          // supplies the +1 of two's complement.
          b_d     = bus.sub ? ~bus.y : bus.y;
          c_d     = bus.carry_in;
          k_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < NSTEPS; i++) begin
          if (k_q == IDXW'(i)) begin
            w_d[i*CHUNK +: CHUNK] = ch_sum;
          end
        end
        c_d = ch_cout;
        k_d = k_q + IDXW'(1);
        if (k_q == K_LAST) begin
          // Publish w_d rather than w_q so the final chunk lands on this edge.
          sum_d   = w_d;
          cout_d  = ch_cout;
          ovf_d   = ch_cmsb ^ ch_cout;
          done_d  = 1'b1;
          k_d     = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      k_q     <= '0;
      w_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      k_q     <= k_d;
      w_q     <= w_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_adder_seq_n.sv
// tb/tb_adder_seq_n.sv - directed self-checking bench for adder_seq_n
module tb_adder_seq_n;
  logic clk;
  logic rst_n;

  int n_checks;
  int n_pass;

  adder_seq_n_if #(.WIDTH(32)) bus32 ();
  adder_seq_n_if #(.WIDTH(8))  bus8 ();

  adder_seq_n #(.WIDTH(32), .CHUNK(8)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  adder_seq_n #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one 32-bit operation and check latency and results.
  task automatic op32(input string tag, input logic [31:0] x, input logic [31:0] y,
                      input logic cin, input logic sb,
                      input logic [31:0] e_sum, input logic e_cout, input logic e_ovf);
    int busy_cycles;
    bus32.start    = 1'b1;
    bus32.x        = x;
    bus32.y        = y;
    bus32.carry_in = cin;
    bus32.sub      = sb;
    tick();
    bus32.start = 1'b0;
    busy_cycles = 0;
    if (bus32.busy) busy_cycles++;
    for (int i = 0; i < 20 && !bus32.done; i++) begin
      tick();
      if (bus32.busy) busy_cycles++;
    end
    check({tag, "_done"},    {31'd0, bus32.done}, 32'd1);
    check({tag, "_latency"}, busy_cycles, 32'd4);
    check({tag, "_sum"},     bus32.sum, e_sum);
    check({tag, "_cout"},    {31'd0, bus32.carry_out}, {31'd0, e_cout});
    check({tag, "_ovf"},     {31'd0, bus32.overflow}, {31'd0, e_ovf});
    tick();
    check({tag, "_done_1cyc"}, {31'd0, bus32.done}, 32'd0);
  endtask

  initial begin
    int dones;
    logic [31:0] seen_sum;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus32.start = 1'b0; bus32.x = '0; bus32.y = '0; bus32.carry_in = 1'b0; bus32.sub = 1'b0;
    bus8.start  = 1'b0; bus8.x  = '0; bus8.y  = '0; bus8.carry_in  = 1'b0; bus8.sub  = 1'b0;
    tick();
    tick();
    check("rst_busy", {31'd0, bus32.busy}, 32'd0);
    check("rst_done", {31'd0, bus32.done}, 32'd0);
    check("rst_sum",  bus32.sum, 32'd0);
    check("rst_cout", {31'd0, bus32.carry_out}, 32'd0);
    check("rst_ovf",  {31'd0, bus32.overflow}, 32'd0);
    rst_n = 1'b1;
    tick();

    op32("wrap",   32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    op32("posovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    op32("negovf", 32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1);
    op32("sub5_7", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    op32("sub7_5", 32'd7, 32'd5, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0);

    // start and operand changes during RUN must be ignored
    bus32.start = 1'b1; bus32.x = 32'h10; bus32.y = 32'h20; bus32.carry_in = 1'b0; bus32.sub = 1'b0;
    tick();
    bus32.start = 1'b0; bus32.x = 32'hDEADBEEF;
    tick();
    bus32.start = 1'b1; bus32.x = 32'hAAAAAAAA; bus32.y = 32'h11111111; bus32.sub = 1'b1;
    tick();
    bus32.start = 1'b0; bus32.x = 32'h5A5A5A5A; bus32.y = 32'hC3C3C3C3;
    dones = 0;
    seen_sum = 32'hFFFFFFFF;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus32.done) begin
        dones++;
        seen_sum = bus32.sum;
      end
    end
    check("ignore_dones", dones, 32'd1);
    check("ignore_sum",   seen_sum, 32'h00000030);
    check("ignore_idle",  {31'd0, bus32.busy}, 32'd0);

    // back-to-back: new start accepted in the done cycle
    bus32.start = 1'b1; bus32.x = 32'd1; bus32.y = 32'd2; bus32.sub = 1'b0;
    tick();
    bus32.start = 1'b0;
    for (int i = 0; i < 20 && !bus32.done; i++) tick();
    check("b2b_first_done", {31'd0, bus32.done}, 32'd1);
    check("b2b_first_sum",  bus32.sum, 32'd3);
    bus32.start = 1'b1; bus32.x = 32'h12345678; bus32.y = 32'h11111111;
    tick();
    bus32.start = 1'b0;
    check("b2b_accepted", {31'd0, bus32.busy}, 32'd1);
    check("b2b_hold0",    bus32.sum, 32'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b2b_hold", {bus32.done, bus32.sum[30:0]}, 32'd3);
    end
    tick();
    check("b2b_done", {31'd0, bus32.done}, 32'd1);
    check("b2b_sum",  bus32.sum, 32'h23456789);

    // reset mid-run aborts
    tick();
    bus32.start = 1'b1; bus32.x = 32'hFFFFFFFF; bus32.y = 32'd1;
    tick();
    bus32.start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("abort_busy", {31'd0, bus32.busy}, 32'd0);
    check("abort_done", {31'd0, bus32.done}, 32'd0);
    check("abort_sum",  bus32.sum, 32'd0);
    check("abort_cout", {31'd0, bus32.carry_out}, 32'd0);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus32.done) dones++;
    end
    check("abort_no_done", dones, 32'd0);

    // single-chunk configuration
    bus8.start = 1'b1; bus8.x = 8'hFF; bus8.y = 8'h01; bus8.carry_in = 1'b0; bus8.sub = 1'b0;
    tick();
    bus8.start = 1'b0;
    check("w8_busy", {31'd0, bus8.busy}, 32'd1);
    check("w8_done_early", {31'd0, bus8.done}, 32'd0);
    tick();
    check("w8_done", {31'd0, bus8.done}, 32'd1);
    check("w8_busy_end", {31'd0, bus8.busy}, 32'd0);
    check("w8_sum",  {24'd0, bus8.sum}, 32'd0);
    check("w8_cout", {31'd0, bus8.carry_out}, 32'd1);
    check("w8_ovf",  {31'd0, bus8.overflow}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/adder_seq_n.md
Name: adder_seq_n

Overview:
Parametrised multi-cycle adder/subtractor and the successor to the fixed 8-bit ripple adder. It processes a WIDTH-bit operand pair CHUNK bits per clock through one registered carry, trading latency for a short critical path. Operands are accepted with a start/done handshake, and the block reports sum, carry_out and signed overflow. It is the arithmetic core for the upcoming wide-datapath ALU labs.

Parameters:
WIDTH, 32, operand/result width in bits; must be an integer multiple of CHUNK
CHUNK, 8, bits added per clock cycle; NSTEPS = WIDTH/CHUNK (>= 1)

Ports:
clk  input  1  single clock; all state changes on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only while idle (busy=0)
x  input  WIDTH  operand A, captured when start is accepted
y  input  WIDTH  operand B, captured when start is accepted
carry_in  input  1  carry into bit 0, captured when start is accepted
sub  input  1  0: x+y+carry_in; 1: x+~y+carry_in (carry_in=1 gives x-y); captured when start is accepted
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when results update
sum  output  WIDTH  result, held until the next completion
carry_out  output  1  carry out of bit WIDTH-1
overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n=0 at an edge):
  - state IDLE; busy=0, done=0, sum=0, carry_out=0, overflow=0.
  - Internal operand, work and carry registers are cleared.
  - Reset mid-operation aborts the operation: no done, outputs zero.
- States: IDLE, RUN.
- IDLE:
  - If start=1 at an edge: latch x into A, (sub ? ~y : y) into B, and carry_in into C.
  - Clear chunk index k=0; go to RUN; busy=1 from that edge.
  - start=0: remain in IDLE; outputs hold.
- RUN, each edge:
  - Chunk k computes A[k*CHUNK +: CHUNK] + B[k*CHUNK +: CHUNK] + C.
  - The chunk sum goes into work register W at chunk k; C takes the chunk carry-out; k increments.
- Last chunk (k = NSTEPS-1), same edge:
  - sum <= full W including the final chunk; carry_out <= final carry.
  - overflow <= carry into bit WIDTH-1 XOR final carry.
  - done <= 1; busy <= 0; state goes to IDLE.
- Latency: busy high for exactly NSTEPS cycles; done pulses in the cycle after the NSTEPS-th RUN edge (e.g. 4 cycles for 32/8; 1 cycle when CHUNK=WIDTH).
- done stays high for exactly one cycle unless a new operation completes immediately after.
- start while busy=1 is ignored; inputs may change freely during RUN with no effect on the result.
- Back-to-back: start=1 in the done cycle (state IDLE) is accepted. The old results stay on sum/carry_out/overflow until the new operation completes.
- Arithmetic is modulo 2^WIDTH; no saturation. overflow is meaningful for two's-complement interpretation only.
- sum/carry_out/overflow change only on a completion edge or on reset.

Decomposition:
- Shared package: state encoding (ST_IDLE, ST_RUN) and an index-width helper constant $clog2(NSTEPS) (min 1).
- Natural sub-module: adder_chunk, a CHUNK-bit ripple adder built from the existing full_adder cells.
  - Outputs: sum, carry_out, and carry into its MSB (needed for overflow).
  - One instance, time-multiplexed across chunks.

Test Plan:
- WIDTH=32, CHUNK=8: x=0xFFFFFFFF, y=0x00000001, cin=0, sub=0 -> after 4 busy cycles done=1, sum=0x00000000, carry_out=1, overflow=0.
- x=0x7FFFFFFF, y=1, cin=0, sub=0 -> sum=0x80000000, carry_out=0, overflow=1; x=0x80000000, y=0x80000000 -> sum=0, carry_out=1, overflow=1.
- Subtract: x=5, y=7, sub=1, cin=1 -> sum=0xFFFFFFFE, carry_out=0 (borrow), overflow=0; x=7, y=5 -> sum=2, carry_out=1.
- Pulse start again at RUN cycle 2 with different operands, and change x/y mid-run -> ignored; result is the first operation's; exactly one done pulse.
- Back-to-back: start held through the done cycle with new operands 0x12345678+0x11111111 -> accepted in that cycle; previous sum held for 4 cycles, then sum=0x23456789.
- Drive rst_n=0 at RUN cycle 2 -> next cycle busy=0, done=0, sum=0; no done pulse. With CHUNK=WIDTH=8: 0xFF+0x01 -> done one cycle after start, sum=0x00, carry_out=1.
